ieee754_to_int: RTL and testbench

//  Downstream partner of the integer->float converter. Takes one IEEE754 single-precision word and returns a

---
 rtl/ieee754_pkg.sv | 9 +
 rtl/f32_unpack.sv | 24 ++
 rtl/ieee754_to_int.sv | 154 +++++++++++++++
 tb/tb_ieee754_to_int.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ieee754_pkg.sv
// ieee754_pkg: single-precision field constants and converter FSM states,
// shared by the float<->int converters.
package ieee754_pkg;
   localparam int EXP_W = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_SHIFT, S_ROUND, S_SIGN, S_DONE} state_t;
endpackage

// File: rtl/f32_unpack.sv
// f32_unpack: splits a single-precision word into sign/fraction, classifies it
// and returns the unbiased exponent.
module f32_unpack
   import ieee754_pkg::*;
(
   input  logic [31:0]       word_i,
   output logic              sign_o,
   output logic [FRAC_W-1:0] frac_o,
   output logic              zero_o,
   output logic              denorm_o,
   output logic              inf_o,
   output logic              nan_o,
   output logic signed [8:0] e_o
);
   logic [EXP_W-1:0] ex;
   assign sign_o   = word_i[31];
   assign ex       = word_i[30:23];
   assign frac_o   = word_i[22:0];
   assign zero_o   = ex == '0 && frac_o == '0;
   assign denorm_o = ex == '0 && frac_o != '0;
   assign inf_o    = ex == EXP_SPECIAL && frac_o == '0;
   assign nan_o    = ex == EXP_SPECIAL && frac_o != '0;
   assign e_o      = $signed({1'b0, ex} - 9'(BIAS));
endmodule

// File: rtl/ieee754_to_int.sv
// ieee754_to_int: iterative float -> saturating signed integer converter.
// Define IEEE754_TO_INT_ROUND_EN for round-to-nearest-even (default truncates).
module ieee754_to_int
   import ieee754_pkg::*;
#(
   parameter int OUT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [31:0]          Data754,
   input  logic                 inputCS,
   output logic [OUT_WIDTH-1:0] IntOutput,
   output logic                 outputCS,
   output logic                 busy,
   output logic                 ovf,
   output logic                 nan
);
   localparam int W = OUT_WIDTH;
   localparam int MW = W > 24 ? W : 24;
   localparam logic [MW-1:0] POS_LIM = MW'((64'd1 << (W - 1)) - 64'd1);
   localparam logic [MW-1:0] NEG_LIM = MW'(64'd1 << (W - 1));
   localparam logic signed [8:0] E_TOP = 9'(W - 1);
   state_t state_q, state_d;
   logic cs_q;
   logic [31:0] data_q, data_d;
   logic [MW-1:0] mag_q, mag_d, rnd, lim;
   logic [4:0] n_q, n_d;
   logic left_q, left_d, sat_q, sat_d;
   logic [W-1:0] int_q, int_d;
   logic ocs_q, ocs_d, ovf_q, ovf_d, nan_q, nan_d;
   logic sign, f_zero, f_denorm, f_inf, f_nan;
   logic [FRAC_W-1:0] frac;
   logic signed [8:0] e;
   f32_unpack u_unpack (
      .word_i(data_q), .sign_o(sign), .frac_o(frac), .zero_o(f_zero),
      .denorm_o(f_denorm), .inf_o(f_inf), .nan_o(f_nan), .e_o(e)
   );
   function automatic logic [W-1:0] sat_val(input logic s);
      return s ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
   endfunction
`ifdef IEEE754_TO_INT_ROUND_EN
   localparam logic signed [8:0] E_MIN = -9'sd1;
   logic guard_q, guard_d, sticky_q, sticky_d;
   assign rnd = mag_q + MW'(guard_q && (sticky_q || mag_q[0]));
`else
   localparam logic signed [8:0] E_MIN = 9'sd0;
   assign rnd = mag_q;
`endif
   assign lim = sign ? NEG_LIM : POS_LIM;
   assign IntOutput = int_q;
   assign outputCS = ocs_q;
   assign ovf = ovf_q;
   assign nan = nan_q;
   assign busy = state_q != S_IDLE;
   always_comb begin
      state_d = state_q;
      data_d = data_q;
      mag_d = mag_q;
      n_d = n_q;
      left_d = left_q;
      sat_d = sat_q;
      int_d = int_q;
      ovf_d = ovf_q;
      nan_d = nan_q;
      ocs_d = 1'b0;
`ifdef IEEE754_TO_INT_ROUND_EN
      guard_d = guard_q;
      sticky_d = sticky_q;
`endif
      case (state_q)
         S_IDLE: begin
            data_d = (inputCS && !cs_q) ? Data754 : data_q;
            state_d = (inputCS && !cs_q) ? S_UNPACK : S_IDLE;
         end
         S_UNPACK: begin
            mag_d = MW'({1'b1, frac});
            left_d = e > 9'sd23;
            n_d = left_d ? 5'(e - 9'sd23) : 5'(9'sd23 - e);
            sat_d = 1'b0;
`ifdef IEEE754_TO_INT_ROUND_EN
            guard_d = 1'b0;
            sticky_d = 1'b0;
`endif
            state_d = n_d == '0 ? S_ROUND : S_SHIFT;
            // Specials, tiny values and out-of-range exponents finish immediately
            if (f_nan || f_zero || f_denorm || e < E_MIN || e >= E_TOP) begin
               state_d = S_DONE;
               ocs_d = 1'b1;
               nan_d = f_nan;
               ovf_d = f_inf || (!f_nan && e >= E_TOP && !(sign && e == E_TOP && frac == '0));
               int_d = (f_nan || f_zero || f_denorm || e < E_MIN) ? '0 : sat_val(sign);
            end
         end
         S_SHIFT: begin
            mag_d = left_q ? mag_q << 1 : mag_q >> 1;
`ifdef IEEE754_TO_INT_ROUND_EN
            guard_d = left_q ? guard_q : mag_q[0];
            sticky_d = sticky_q | guard_q;
`endif
            n_d = n_q - 5'd1;
            state_d = n_q == 5'd1 ? S_ROUND : S_SHIFT;
         end
         S_ROUND: begin
            sat_d = rnd > lim;
            mag_d = sat_d ? lim : rnd;
            state_d = S_SIGN;
         end
         S_SIGN: begin
            int_d = sign ? W'(-mag_q) : W'(mag_q);
            ovf_d = sat_q;
            nan_d = 1'b0;
            ocs_d = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         cs_q <= 1'b0;
         data_q <= '0;
         mag_q <= '0;
         n_q <= '0;
         left_q <= 1'b0;
         sat_q <= 1'b0;
         int_q <= '0;
         ocs_q <= 1'b0;
         ovf_q <= 1'b0;
         nan_q <= 1'b0;
`ifdef IEEE754_TO_INT_ROUND_EN
         guard_q <= 1'b0;
         sticky_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cs_q <= inputCS;
         data_q <= data_d;
         mag_q <= mag_d;
         n_q <= n_d;
         left_q <= left_d;
         sat_q <= sat_d;
         int_q <= int_d;
         ocs_q <= ocs_d;
         ovf_q <= ovf_d;
         nan_q <= nan_d;
`ifdef IEEE754_TO_INT_ROUND_EN
         guard_q <= guard_d;
         sticky_q <= sticky_d;
`endif
      end
   end
endmodule

// File: tb/tb_ieee754_to_int.sv
// tb_ieee754_to_int: scoreboard bench for ieee754_to_int (OUT_WIDTH=16) with an
// arithmetic reference model; follows IEEE754_TO_INT_ROUND_EN like the design.
module tb_ieee754_to_int;
   localparam int W = 16;
   localparam logic [W-1:0] MAXV = {1'b0, {(W - 1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W - 1){1'b0}}};
`ifdef IEEE754_TO_INT_ROUND_EN
   localparam int E_MIN = -1;
   localparam logic [W-1:0] ONE_P5 = 16'd2;
`else
   localparam int E_MIN = 0;
   localparam logic [W-1:0] ONE_P5 = 16'd1;
`endif
   logic CLK = 1'b0, RST = 1'b0, inputCS = 1'b0;
   logic [31:0] Data754 = '0;
   logic [W-1:0] IntOutput;
   logic outputCS, busy, ovf, nan;
   ieee754_to_int #(.OUT_WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .Data754(Data754), .inputCS(inputCS),
      .IntOutput(IntOutput), .outputCS(outputCS), .busy(busy), .ovf(ovf), .nan(nan)
   );
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;
   typedef struct {
      logic [W-1:0] v;
      logic o;
      logic n;
      int lat;
      int c0;
   } exp_t;
   exp_t q[$];
   exp_t mon_x;
   int passed = 0, total = 0, pulses = 0, issued = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
   endtask
   // Value = {1,frac} * 2^(e-23), rounded/truncated on the integer grid, then saturated
   function automatic void model(input logic [31:0] w, output logic [W-1:0] v, output logic o,
                                 output logic n, output int lat);
      int e, sh;
      longint m, ip, rem, lim;
      logic s, big;
`ifdef IEEE754_TO_INT_ROUND_EN
      longint half;
`endif
      s = w[31];
      e = int'(w[30:23]) - 127;
      m = longint'({1'b1, w[22:0]});
      lim = longint'(1) << (W - 1);
      v = '0;
      o = 1'b0;
      n = 1'b0;
      lat = 2;
      if (w[30:23] == 8'hFF) begin
         n = w[22:0] != '0;
         o = !n;
         v = o ? (s ? MINV : MAXV) : '0;
         return;
      end
      if (w[30:23] == 8'h00 || e < E_MIN) return;
      sh = 0;
      rem = 0;
      if (e >= 40) ip = lim * 4;
      else if (e >= 23) ip = m << (e - 23);
      else begin
         sh = 23 - e;
         ip = m >> sh;
         rem = m - (ip << sh);
      end
      big = s ? (ip > lim || (ip == lim && rem != 0)) : (ip >= lim);
      lat = (e >= W - 1) ? 2 : ((e <= 23) ? 23 - e : e - 23) + 4;
`ifdef IEEE754_TO_INT_ROUND_EN
      half = sh > 0 ? longint'(1) << (sh - 1) : 0;
      if (sh > 0 && (rem > half || (rem == half && ip[0]))) ip++;
`endif
      if (big || ip > (s ? lim : lim - 1)) begin
         o = 1'b1;
         v = s ? MINV : MAXV;
      end else v = s ? W'(-ip) : W'(ip);
   endfunction
   always @(negedge CLK) begin
      if (outputCS) begin
         pulses++;
         chk("outputCS_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            mon_x = q.pop_front();
            chk("IntOutput", 32'(IntOutput), 32'(mon_x.v));
            chk("ovf", 32'(ovf), 32'(mon_x.o));
            chk("nan", 32'(nan), 32'(mon_x.n));
            chk("latency", 32'(cyc - mon_x.c0 + 1), 32'(mon_x.lat));
         end
      end
   end
   task automatic start(input logic [31:0] w, input logic [W-1:0] v, input logic o, input logic n,
                        input int lat);
      exp_t x;
      @(negedge CLK);
      Data754 = w;
      inputCS = 1'b1;
      x.v = v;
      x.o = o;
      x.n = n;
      x.lat = lat;
      x.c0 = cyc + 1;
      q.push_back(x);
      issued++;
      @(negedge CLK);
      inputCS = 1'b0;
      Data754 = $urandom;
   endtask
   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 80) begin
         @(negedge CLK);
         #1;
         k++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
      issued -= q.size();
      q.delete();
   endtask
   task automatic run(input logic [31:0] w);
      logic [W-1:0] v;
      logic o, n;
      int lat;
      model(w, v, o, n, lat);
      start(w, v, o, n, lat);
      drain();
   endtask
   function automatic logic [31:0] rand_word();
      int r;
      logic [7:0] ex;
      r = $urandom_range(0, 9);
      ex = r == 0 ? 8'hFF : r == 1 ? 8'h00 : r == 2 ? 8'(141 + $urandom_range(0, 2))
         : 8'($urandom_range(118, 140));
      return {1'($urandom), ex, r == 3 ? 23'h0 : 23'($urandom)};
   endfunction
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (2) @(negedge CLK);
      chk("reset_IntOutput", 32'(IntOutput), 32'd0);
      chk("reset_outputCS", 32'(outputCS), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      chk("reset_nan", 32'(nan), 32'd0);
      RST = 1'b1;
      start(32'h40490FDB, 16'd3, 1'b0, 1'b0, 26);
      drain();
      start(32'h3FC00000, ONE_P5, 1'b0, 1'b0, 27);
      drain();
      start(32'hC0200000, 16'hFFFE, 1'b0, 1'b0, 26);
      drain();
      start(32'h47000000, 16'h7FFF, 1'b1, 1'b0, 2);
      drain();
      start(32'hC7000000, 16'h8000, 1'b0, 1'b0, 2);
      drain();
      start(32'h7F800000, 16'h7FFF, 1'b1, 1'b0, 2);
      drain();
      start(32'h7FC00000, 16'h0000, 1'b0, 1'b1, 2);
      drain();
      start(32'h00000001, 16'h0000, 1'b0, 1'b0, 2);
      drain();
      for (int i = 0; i < 60; i++) run(rand_word());
      // Held start request: one conversion only
      @(negedge CLK);
      Data754 = 32'h40490FDB;
      inputCS = 1'b1;
      mon_x.v = 16'd3;
      mon_x.o = 1'b0;
      mon_x.n = 1'b0;
      mon_x.lat = 26;
      mon_x.c0 = cyc + 1;
      q.push_back(mon_x);
      issued++;
      repeat (50) @(negedge CLK);
      inputCS = 1'b0;
      repeat (5) @(negedge CLK);
      chk("hold_pending", 32'(q.size()), 32'd0);
      // Edge while busy must be dropped
      start(32'h41200000, 16'd10, 1'b0, 1'b0, 24);
      repeat (3) @(negedge CLK);
      Data754 = 32'h42C80000;
      inputCS = 1'b1;
      @(negedge CLK);
      inputCS = 1'b0;
      drain();
      repeat (30) @(negedge CLK);
      // Edge arriving in the DONE cycle must be dropped
      start(32'h7FC00000, 16'h0000, 1'b0, 1'b1, 2);
      @(negedge CLK);
      Data754 = 32'h40490FDB;
      inputCS = 1'b1;
      @(negedge CLK);
      inputCS = 1'b0;
      repeat (30) @(negedge CLK);
      // Result holds during the next conversion; reset aborts it
      run(32'hC0200000);
      start(32'h40490FDB, 16'd3, 1'b0, 1'b0, 26);
      repeat (3) @(negedge CLK);
      chk("hold_IntOutput", 32'(IntOutput), 32'h0000FFFE);
      RST = 1'b0;
      #1;
      chk("abort_IntOutput", 32'(IntOutput), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_outputCS", 32'(outputCS), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      chk("abort_nan", 32'(nan), 32'd0);
      issued -= q.size();
      q.delete();
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      start(32'h40490FDB, 16'd3, 1'b0, 1'b0, 26);
      drain();
      repeat (5) @(negedge CLK);
      chk("pulse_count", 32'(pulses), 32'(issued));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
